// File: rtl/timer_run_ctrl.sv
// rtl/timer_run_ctrl.sv - Button conditioning, prescaler and run/pause/done sequencer for the BCD timer
// Optional build macro: TIMER_RUN_CTRL_AUTO_RELOAD_EN (reload on terminal count instead of entering DONE).
module timer_run_ctrl #(
  parameter int PRESC_DIV  = 1000,
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       mode,
  input  logic       cnt_zero,
  input  logic       cnt_max,
  output logic       cnt_clr,
  output logic       cnt_load,
  output logic       cnt_step,
  output logic       cnt_up,
  output logic [1:0] state,
  output logic       done
);

  localparam int PW = $clog2(PRESC_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          st;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [1:0]      deb_lvl;
  logic [1:0]      deb_lvl_q;
  logic [DW-1:0]   deb_cnt [2];
  logic [PW-1:0]   presc;
  logic            start_p;
  logic            stop_p;
  logic            mode_s;
  logic            tick;
  logic            terminal;

  assign state = st;

  // Bit 2 carries mode: synchronised only, never debounced.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode, stop_btn, start_btn};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl    <= '0;
      deb_lvl_q  <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      deb_lvl_q <= deb_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            deb_lvl[i] <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign start_p  = deb_lvl[0] & ~deb_lvl_q[0];
  assign stop_p   = deb_lvl[1] & ~deb_lvl_q[1];
  assign mode_s   = sync2[2];
  assign tick     = (st == RUN) && (presc == PW'(PRESC_DIV - 1));
  assign terminal = cnt_up ? cnt_max : cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      cnt_step <= 1'b0;
      cnt_up   <= 1'b1;
      done     <= 1'b0;
      presc    <= '0;
    end else begin
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      cnt_step <= 1'b0;
`ifdef TIMER_RUN_CTRL_AUTO_RELOAD_EN
      done     <= 1'b0;
`endif
      // Prescaler only advances in RUN, so PAUSE keeps its phase.
      if (st == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
      end

      case (st)
        IDLE: begin
          if (stop_p) begin
            cnt_clr <= 1'b1;
          end else if (start_p) begin
            cnt_up   <= ~mode_s;
            cnt_load <= mode_s;
            cnt_clr  <= ~mode_s;
            presc    <= '0;
            st       <= RUN;
          end
        end
        RUN: begin
          if (stop_p) begin
            st <= PAUSE;
          end else if (tick) begin
            if (terminal) begin
`ifdef TIMER_RUN_CTRL_AUTO_RELOAD_EN
              cnt_clr  <= cnt_up;
              cnt_load <= ~cnt_up;
              done     <= 1'b1;
`else
              st       <= DONE;
              done     <= 1'b1;
`endif
            end else begin
              cnt_step <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop_p) begin
            cnt_clr <= 1'b1;
            st      <= IDLE;
          end else if (start_p) begin
            st <= RUN;
          end
        end
        DONE: begin
          if (stop_p) begin
            cnt_clr <= 1'b1;
            done    <= 1'b0;
            st      <= IDLE;
          end else if (start_p) begin
            cnt_up   <= ~mode_s;
            cnt_load <= mode_s;
            cnt_clr  <= ~mode_s;
            presc    <= '0;
            done     <= 1'b0;
            st       <= RUN;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
